dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per access (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the pipeline MEM stage presents an access.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_sel, input, 4 bits: byte-lane enables; sel[3] = wdata[31:24] (byte offset 0, big-endian) through sel[0] = wdata[7:0].
REQ-009 SHALL have port req_wdata, input, 32 bits: lane-aligned store data.
REQ-010 SHALL have port req_ready, output, 1 bit: request accepted this cycle.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: raw word read (unshifted, all four lanes).
REQ-013 SHALL have port rsp_err, output, 1 bit: out-of-range address, valid with rsp_valid.
REQ-014 SHALL have port stall, output, 1 bit: freeze the pipeline while an access is pending.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS, RESP.
REQ-016 SHALL, in IDLE, drive req_ready=1 and on req_valid capture we/addr/sel/wdata, then go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
REQ-017 SHALL load a 4-bit counter with WAIT_CYCLES-1 on entry to WAIT, decrement each cycle, and move to ACCESS when it reads 0.
REQ-018 SHALL, in ACCESS, write only lanes with captured sel bit set (store) or read the full word (load), then go to RESP.
REQ-019 SHALL, in RESP, pulse rsp_valid for exactly one cycle, drive rsp_rdata (read word for loads, 0 for stores), and return to IDLE.
REQ-020 SHALL hold req_ready=0 in WAIT, ACCESS and RESP; requests presented there are ignored.
REQ-021 SHALL give latency from accept edge T to rsp_valid high in cycle T+WAIT_CYCLES+2.
REQ-022 SHALL drive stall = (IDLE and req_valid) or WAIT or ACCESS; stall low in RESP so the pipeline advances with the response.
REQ-023 SHALL flag out-of-range when captured addr[31:ADDR_W+2] is nonzero: no write, rsp_rdata=0, rsp_err=1 during RESP.
REQ-024 SHALL treat a store with sel=4'b0000 as a no-op that still completes with rsp_valid.
REQ-025 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid is 0.
REQ-026 SHALL accept a new request in the IDLE cycle immediately after RESP (back-to-back throughput: one access per WAIT_CYCLES+3 cycles).

Reset
REQ-027 SHALL on rst_n low force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
REQ-028 SHALL abort an in-flight access on reset; a store reset before ACCESS leaves memory unchanged.
REQ-029 SHALL not initialise memory contents on reset.

Structure
REQ-030 SHALL place FSM state encodings and lane-index constants in the shared definitions header used by the load/store formatter.
REQ-031 SHALL instantiate one sub-module dmem_bank: 2^ADDR_W x 32 synchronous RAM with 4 byte-write enables.

Verification
REQ-032 SHALL cover: store addr 0x10, sel 1111, wdata 0xDEADBEEF, then load 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid at T+3 (WAIT_CYCLES=1).
REQ-033 SHALL cover: store addr 0x11, sel 0100, wdata 0x00AA0000 over 0xDEADBEEF -> load reads 0xDEAABEEF.
REQ-034 SHALL cover: load addr 0x0001_0000 with ADDR_W=10 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-035 SHALL cover: WAIT_CYCLES=0 and =3 -> rsp_valid at T+2 and T+5; stall high every cycle before RESP.
REQ-036 SHALL cover: rst_n low during WAIT of store 0x12345678 to 0x20 -> state IDLE, no rsp_valid, later load 0x20 returns prior contents.
REQ-037 SHALL cover: req_valid held high continuously -> accepts only in IDLE, exactly one rsp_valid per accepted request.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder and its RAM bank:
//   - state_t          : responder FSM state encoding
//   - NUM_LANES/LANE_W : byte-lane geometry of a 32-bit word
//   - LANE_B0/LANE_B3  : lane index of byte offset 0 (MSB, big-endian) and 3
//   - addr_out_of_range: true when a byte address lies above the memory
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    // Big-endian: byte offset 0 lives in the most significant lane.
    localparam int LANE_B0   = 3;
    localparam int LANE_B3   = 0;

    // A byte address is out of range when any bit above the word index of a
    // 2^addr_w-word memory is set.
    function automatic logic addr_out_of_range(input logic [31:0] byte_addr,
                                               input int          addr_w);
        return (byte_addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// -----------------------------------------------------------------------------
// dmem_bank
// 2^ADDR_W x 32-bit synchronous RAM built from one byte-wide array per lane,
// so each lane carries its own write enable. Read data is registered and
// appears the cycle after en is sampled high. Contents are never reset.
// Ports:
//   clk   - clock
//   en    - read enable (captures mem[addr] into the read register)
//   we    - per-lane write enables, we[i] writes wdata[8i+7:8i]
//   addr  - word address
//   wdata - write data, lane aligned
//   rdata - registered read data (all four lanes)
// -----------------------------------------------------------------------------
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem_lane [DEPTH];
            logic [LANE_W-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_lane[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
                if (en) begin
                    rd_q <= mem_lane[addr];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for a pipeline MEM stage. One access is
// accepted in IDLE, optionally delayed WAIT_CYCLES wait states, performed in
// ACCESS and answered with a single-cycle response in RESP.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_we       - access request, 1 = store / 0 = load
//   req_addr               - byte address (bits [1:0] ignored)
//   req_sel                - byte-lane enables, sel[3] = wdata[31:24]
//   req_wdata              - lane-aligned store data
//   req_ready              - high in IDLE: request accepted this cycle
//   rsp_valid              - one-cycle completion pulse
//   rsp_rdata              - raw read word (0 for stores / errors / idle)
//   rsp_err                - out-of-range address, valid with rsp_valid
//   stall                  - freeze the pipeline while an access is pending
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    // Counter preload on WAIT entry; the counter counts down to 0 inclusive,
    // so WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                oob_q, oob_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;

    logic                bank_en;
    logic [NUM_LANES-1:0] bank_we;
    logic [31:0]         bank_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        word_d  = word_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        oob_d   = oob_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    word_d  = req_addr[ADDR_W+1:2];
                    sel_d   = req_sel;
                    wdata_d = req_wdata;
                    oob_d   = addr_out_of_range(req_addr, ADDR_W);
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the next state.
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = (state_d == RESP) && oob_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            word_q      <= '0;
            sel_q       <= 4'd0;
            wdata_q     <= 32'd0;
            oob_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            word_q      <= word_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            oob_q       <= oob_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Out-of-range accesses never touch the RAM.
    assign bank_en = (state_q == ACCESS) && !we_q && !oob_q;
    assign bank_we = ((state_q == ACCESS) && we_q && !oob_q) ? sel_q : '0;

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (word_q),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // The RAM read register holds stale data outside RESP; mask it to 0.
    assign rsp_rdata = (rsp_valid_q && !we_q && !oob_q) ? bank_rdata : 32'd0;
    // stall is partly combinational on req_valid so the stage freezes in the
    // very cycle its request is accepted.
    assign stall     = rst_n && (((state_q == IDLE) && req_valid) ||
                                 (state_q == WAIT) || (state_q == ACCESS));

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (WAIT_CYCLES = 0, 1, 3; ADDR_W = 10) driven from tasks.
// A per-instance word array models memory: stores merge enabled byte lanes,
// loads return the stored word, addresses >= 4096 are errors with no effect.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [3:0]  req_sel   [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        stall     [3];

    logic [31:0] mdl [3][32];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            dmem_responder #(
                .ADDR_W      (10),
                .WAIT_CYCLES ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid[gi]),
                .req_we    (req_we[gi]),
                .req_addr  (req_addr[gi]),
                .req_sel   (req_sel[gi]),
                .req_wdata (req_wdata[gi]),
                .req_ready (req_ready[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi]),
                .stall     (stall[gi])
            );
        end
    endgenerate

    function automatic int wc(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    // Reference model: expected response of one access, updating memory.
    task automatic model_apply(input int i, input bit we, input logic [31:0] a,
                               input logic [3:0] sel, input logic [31:0] d,
                               output logic [31:0] exp_rd, output logic exp_err);
        int w;
        w       = int'((a >> 2) % 32);
        exp_err = (a >= 32'h1000);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mdl[i][w][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                exp_rd = mdl[i][w];
            end
        end
    endtask

    // One access on instance i. lat = cycles from the accept cycle to the
    // rsp_valid cycle (-1 on timeout). bad counts cycles where stall,
    // idle-zero outputs or the single-cycle pulse were wrong.
    task automatic access(input int i, input bit we, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int bad);
        int  k;
        bit  done;
        bad = 0; lat = -1; rd = 32'd0; er = 1'b0; done = 1'b0;
        @(negedge clk);
        req_we[i] = we; req_addr[i] = a; req_sel[i] = sel; req_wdata[i] = d;
        req_valid[i] = 1'b1;
        #1;
        k = 0;
        while (req_ready[i] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (req_ready[i] === 1'b1) begin
            if (stall[i] !== 1'b1) bad++;
            k = 0;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
                req_valid[i] = 1'b0;
                if (rsp_valid[i] === 1'b1) begin
                    lat = k; rd = rsp_rdata[i]; er = rsp_err[i];
                    if (stall[i] !== 1'b0) bad++;
                    done = 1'b1;
                end else if (stall[i] !== 1'b1 || rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
                    bad++;
                end
            end
            if (done) begin
                @(negedge clk);
                if (rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'd0 ||
                    rsp_err[i] !== 1'b0 || req_ready[i] !== 1'b1) bad++;
            end
        end
        req_valid[i] = 1'b0;
        $display("txn inst=%0d we=%0d addr=%h sel=%b wdata=%h -> rdata=%h err=%0d lat=%0d bad=%0d",
                 i, we, a, sel, d, rd, er, lat, bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (req_ready[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", i, req_ready[i]); else n_pass++;
            n_checks++; if (rsp_valid[i] !== 1'b0) $display("FAIL reset_rsp_valid[%0d]: got %b want 0", i, rsp_valid[i]); else n_pass++;
            n_checks++; if (rsp_rdata[i] !== 32'd0) $display("FAIL reset_rdata[%0d]: got %h want 0", i, rsp_rdata[i]); else n_pass++;
            n_checks++; if (rsp_err[i] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", i, rsp_err[i]); else n_pass++;
            n_checks++; if (stall[i] !== 1'b0) $display("FAIL reset_stall[%0d]: got %b want 0", i, stall[i]); else n_pass++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Give words 0..31 of every instance known contents.
    task automatic test_fill();
        logic [31:0] rd, erd, d;
        logic        er, eer;
        int          lat, bad;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 32; w++) begin
                d = $urandom;
                access(i, 1'b1, 32'(w * 4), 4'hF, d, rd, er, lat, bad);
                model_apply(i, 1'b1, 32'(w * 4), 4'hF, d, erd, eer);
                n_checks++; if (lat != wc(i) + 2) $display("FAIL fill_lat[%0d]: got %0d want %0d", i, lat, wc(i) + 2); else n_pass++;
                n_checks++; if (rd !== erd || er !== eer || bad != 0) $display("FAIL fill_rsp[%0d]: got %h/%b/%0d want %h/%b/0", i, rd, er, bad, erd, eer); else n_pass++;
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, bad;
        access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, bad);
        model_apply(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, erd, eer);
        n_checks++; if (lat != 3 || er !== 1'b0 || rd !== 32'd0) $display("FAIL basic_store: got lat %0d err %b rdata %h want 3/0/0", lat, er, rd); else n_pass++;
        access(1, 1'b0, 32'h10, 4'hF, 32'd0, rd, er, lat, bad);
        model_apply(1, 1'b0, 32'h10, 4'hF, 32'd0, erd, eer);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_load_data: got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL basic_load_lat: got %0d want 3", lat); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL basic_stall: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, bad;
        access(1, 1'b1, 32'h11, 4'b0100, 32'h00AA0000, rd, er, lat, bad);
        model_apply(1, 1'b1, 32'h11, 4'b0100, 32'h00AA0000, erd, eer);
        access(1, 1'b0, 32'h10, 4'hF, 32'd0, rd, er, lat, bad);
        model_apply(1, 1'b0, 32'h10, 4'hF, 32'd0, erd, eer);
        n_checks++; if (rd !== 32'hDEAABEEF) $display("FAIL lane_merge: got %h want deaabeef", rd); else n_pass++;
        // sel = 0 store: completes normally, changes nothing.
        access(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, lat, bad);
        model_apply(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, erd, eer);
        n_checks++; if (lat != 3 || er !== 1'b0 || bad != 0) $display("FAIL sel0_complete: got lat %0d err %b bad %0d want 3/0/0", lat, er, bad); else n_pass++;
        access(1, 1'b0, 32'h10, 4'hF, 32'd0, rd, er, lat, bad);
        n_checks++; if (rd !== 32'hDEAABEEF) $display("FAIL sel0_noop: got %h want deaabeef", rd); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, bad;
        access(1, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, rd, er, lat, bad);
        model_apply(1, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, erd, eer);
        n_checks++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL oob_store: got err %b rdata %h want 1/0", er, rd); else n_pass++;
        access(1, 1'b0, 32'h0001_0000, 4'hF, 32'd0, rd, er, lat, bad);
        n_checks++; if (er !== 1'b1) $display("FAIL oob_load_err: got %b want 1", er); else n_pass++;
        n_checks++; if (rd !== 32'd0) $display("FAIL oob_load_data: got %h want 0", rd); else n_pass++;
        n_checks++; if (lat != 3 || bad != 0) $display("FAIL oob_load_timing: got lat %0d bad %0d want 3/0", lat, bad); else n_pass++;
        access(1, 1'b0, 32'h0, 4'hF, 32'd0, rd, er, lat, bad);
        model_apply(1, 1'b0, 32'h0, 4'hF, 32'd0, erd, eer);
        n_checks++; if (rd !== erd || er !== 1'b0) $display("FAIL oob_mem_unchanged: got %h/%b want %h/0", rd, er, erd); else n_pass++;
    endtask

    task automatic test_latency();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, bad;
        for (int i = 0; i < 3; i += 2) begin
            access(i, 1'b0, 32'h14, 4'hF, 32'd0, rd, er, lat, bad);
            model_apply(i, 1'b0, 32'h14, 4'hF, 32'd0, erd, eer);
            n_checks++; if (lat != wc(i) + 2) $display("FAIL latency[%0d]: got %0d want %0d", i, lat, wc(i) + 2); else n_pass++;
            n_checks++; if (bad != 0) $display("FAIL latency_stall[%0d]: got %0d bad cycles want 0", i, bad); else n_pass++;
            n_checks++; if (rd !== erd) $display("FAIL latency_data[%0d]: got %h want %h", i, rd, erd); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, bad, seen;
        @(negedge clk);
        req_we[1] = 1'b1; req_addr[1] = 32'h20; req_sel[1] = 4'hF;
        req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
        #1;
        n_checks++; if (req_ready[1] !== 1'b1) $display("FAIL abort_accept: got ready %b want 1", req_ready[1]); else n_pass++;
        @(negedge clk);            // now in the single wait state
        req_valid[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready[1] !== 1'b1 || stall[1] !== 1'b0) $display("FAIL abort_idle: got ready %b stall %b want 1/0", req_ready[1], stall[1]); else n_pass++;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) $display("FAIL abort_no_rsp: got %0d rsp cycles want 0", seen); else n_pass++;
        access(1, 1'b0, 32'h20, 4'hF, 32'd0, rd, er, lat, bad);
        model_apply(1, 1'b0, 32'h20, 4'hF, 32'd0, erd, eer);
        n_checks++; if (rd !== erd) $display("FAIL abort_mem: got %h want %h", rd, erd); else n_pass++;
    endtask

    task automatic test_back_to_back(input int i);
        int p, ncyc, n_acc, n_rsp, last_acc, spacing_bad, data_bad;
        p = wc(i) + 3; ncyc = 30;
        n_acc = 0; n_rsp = 0; last_acc = -1; spacing_bad = 0; data_bad = 0;
        @(negedge clk);
        req_we[i] = 1'b0; req_addr[i] = 32'h14; req_sel[i] = 4'hF;
        req_wdata[i] = 32'd0; req_valid[i] = 1'b1;
        for (int c = 0; c < ncyc + 12; c++) begin
            if (c == ncyc) req_valid[i] = 1'b0;
            if (req_valid[i] && req_ready[i] === 1'b1) begin
                if (last_acc >= 0 && c - last_acc != p) spacing_bad++;
                last_acc = c;
                n_acc++;
            end
            if (rsp_valid[i] === 1'b1) begin
                n_rsp++;
                if (rsp_rdata[i] !== mdl[i][5]) data_bad++;
            end
            @(negedge clk);
        end
        $display("burst inst=%0d accepts=%0d responses=%0d spacing_bad=%0d data_bad=%0d",
                 i, n_acc, n_rsp, spacing_bad, data_bad);
        n_checks++; if (n_acc != (ncyc + p - 1) / p) $display("FAIL b2b_accepts[%0d]: got %0d want %0d", i, n_acc, (ncyc + p - 1) / p); else n_pass++;
        n_checks++; if (n_rsp != n_acc) $display("FAIL b2b_rsp_count[%0d]: got %0d want %0d", i, n_rsp, n_acc); else n_pass++;
        n_checks++; if (spacing_bad != 0) $display("FAIL b2b_spacing[%0d]: got %0d bad gaps want 0", i, spacing_bad); else n_pass++;
        n_checks++; if (data_bad != 0) $display("FAIL b2b_data[%0d]: got %0d bad words want 0", i, data_bad); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d;
        logic [3:0]  sel;
        logic        er, eer;
        bit          we;
        int          lat, bad;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 40; n++) begin
                we  = 1'($urandom_range(0, 1));
                a   = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(12, 31));
                sel = 4'($urandom_range(0, 15));
                d   = $urandom;
                access(i, we, a, sel, d, rd, er, lat, bad);
                model_apply(i, we, a, sel, d, erd, eer);
                n_checks++; if (rd !== erd) $display("FAIL rand_rdata[%0d]: got %h want %h", i, rd, erd); else n_pass++;
                n_checks++; if (er !== eer) $display("FAIL rand_err[%0d]: got %b want %b", i, er, eer); else n_pass++;
                n_checks++; if (lat != wc(i) + 2 || bad != 0) $display("FAIL rand_timing[%0d]: got lat %0d bad %0d want %0d/0", i, lat, bad, wc(i) + 2); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'd0;
            req_sel[i] = 4'd0; req_wdata[i] = 32'd0;
        end
        rst_n = 1'b1;
        test_reset();
        test_fill();
        test_basic();
        test_byte_lane();
        test_out_of_range();
        test_latency();
        test_reset_abort();
        test_back_to_back(0);
        test_back_to_back(2);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
